// File: rtl/fec_block_sequencer_ble.sv
// fec_block_sequencer_ble
//   Feeds a BLE payload, one bit per cycle, into the bit-serial (15,10) shortened
//   Hamming encoder. Payload bytes arrive on a valid/ready stream and are sent
//   LSB-first in code blocks of DATA_BITS bits. The last block is zero-padded.
//   After every block the encoder valid is held low for GAP_CYCLES cycles, so the
//   encoder can shift out parity and clear itself.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   start, payload_len    start pulse (sampled in IDLE only), length in bytes
//   byte_in, byte_valid   payload byte stream
//   byte_ready            the sequencer accepts a byte this cycle
//   enc_data_in           serial bit to the encoder (0 whenever enc_valid_in is 0)
//   enc_valid_in          encoder valid_in
//   busy                  high from an accepted non-empty start until done
//   done                  one-cycle pulse when the payload is fully sequenced
//   blocks_sent           completed code blocks of the current or last payload
//
// Every output is a flop. Where a flop has to reflect the state of the same
// cycle, it is loaded from the next-state values.
module fec_block_sequencer_ble #(
  parameter int LEN_W      = 8,
  parameter int DATA_BITS  = 10,
  parameter int GAP_CYCLES = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] payload_len,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             enc_data_in,
  output logic             enc_valid_in,
  output logic             busy,
  output logic             done,
  output logic [LEN_W:0]   blocks_sent
);

  localparam int BITS_W = LEN_W + 3;
  localparam int BLK_W  = $clog2(DATA_BITS + 1);
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(DATA_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, FEED, PAD, GAP, DONE} state_t;

  state_t            state, state_nxt;
  logic [BITS_W-1:0] bits_left;
  logic [LEN_W-1:0]  bytes_left, bytes_left_nxt;
  logic [7:0]        shreg;
  logic [2:0]        bit_idx;
  logic              full, full_nxt;
  logic [BLK_W-1:0]  blk_bit;
  logic [GAP_W-1:0]  gap_cnt;

  logic enc_data_nxt, enc_valid_nxt, busy_nxt, done_nxt, byte_ready_nxt;

  logic accept, emit_buf, emit_new, emit, emit_bit;
  logic blk_end, last_bit, start_ok, len_zero, gap_entry;

  // A new byte is only accepted while the buffer is empty. Its bit 0 goes
  // straight to the output flop, so the stream has no bubble between bytes.
  assign accept    = byte_valid && byte_ready;
  assign emit_buf  = (state == FEED) && full;
  assign emit_new  = (state == FEED) && !full && accept;
  assign emit      = emit_buf || emit_new;
  assign emit_bit  = full ? shreg[0] : byte_in[0];
  assign blk_end   = (blk_bit == BLK_LAST);
  assign last_bit  = (bits_left == BITS_W'(1));
  assign start_ok  = (state == IDLE) && start;
  assign len_zero  = (payload_len == '0);
  assign gap_entry = (state_nxt == GAP) && (state != GAP);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A block that ends on the last payload bit goes straight to GAP, with no pad.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = len_zero ? DONE : FEED;
      FEED: begin
        if (emit) begin
          if (blk_end)       state_nxt = GAP;
          else if (last_bit) state_nxt = PAD;
        end
      end
      PAD:  if (blk_end) state_nxt = GAP;
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = (bits_left != '0) ? FEED : DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    full_nxt       = full;
    bytes_left_nxt = bytes_left;
    if (start_ok) begin
      full_nxt       = 1'b0;
      bytes_left_nxt = payload_len;
    end else begin
      if (accept)                        bytes_left_nxt = bytes_left - LEN_W'(1);
      if (emit_buf && (bit_idx == 3'd7)) full_nxt = 1'b0;
      if (emit_new)                      full_nxt = 1'b1;
    end
  end

  always_comb begin
    enc_data_nxt  = 1'b0;
    enc_valid_nxt = 1'b0;
    busy_nxt      = 1'b0;
    done_nxt      = 1'b0;
    case (state)
      IDLE: busy_nxt = start && !len_zero;
      FEED: begin
        busy_nxt = 1'b1;
        if (emit) begin
          enc_valid_nxt = 1'b1;
          enc_data_nxt  = emit_bit;
        end
      end
      PAD: begin
        busy_nxt      = 1'b1;
        enc_valid_nxt = 1'b1;
      end
      GAP:     busy_nxt = 1'b1;
      DONE:    done_nxt = 1'b1;
      default: busy_nxt = 1'b0;
    endcase
    byte_ready_nxt = (state_nxt == FEED) && !full_nxt && (bytes_left_nxt != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enc_data_in  <= 1'b0;
      enc_valid_in <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      byte_ready   <= 1'b0;
    end else begin
      enc_data_in  <= enc_data_nxt;
      enc_valid_in <= enc_valid_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      byte_ready   <= byte_ready_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bits_left   <= '0;
      bytes_left  <= '0;
      bit_idx     <= '0;
      full        <= 1'b0;
      blk_bit     <= '0;
      gap_cnt     <= '0;
      blocks_sent <= '0;
    end else begin
      full       <= full_nxt;
      bytes_left <= bytes_left_nxt;
      if (start_ok) begin
        bits_left   <= {payload_len, 3'b000};
        blocks_sent <= '0;
        blk_bit     <= '0;
      end
      if (emit_buf) bit_idx   <= bit_idx + 3'd1;
      if (emit_new) bit_idx   <= 3'd1;
      if (emit)     bits_left <= bits_left - BITS_W'(1);
      if (gap_entry) begin
        blk_bit <= '0;
        gap_cnt <= '0;
        if (blocks_sent != '1) blocks_sent <= blocks_sent + (LEN_W+1)'(1);
      end else if (emit || (state == PAD)) begin
        blk_bit <= blk_bit + BLK_W'(1);
      end
      if (state == GAP) gap_cnt <= gap_cnt + GAP_W'(1);
    end
  end

  // Byte shift register: pure data. Whether its contents mean anything is
  // tracked only by full/bit_idx.
  always_ff @(posedge clk) begin
    if (emit_buf) shreg <= shreg >> 1;
    if (emit_new) shreg <= byte_in >> 1;
  end

endmodule
